multicycle_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair SLICE bits per clock through a registered carry chain.
- Successor to the single-bit full-adder cell. Adds width generalisation, subtract mode, a start/done handshake, and signed-overflow reporting.
- Used by datapaths that trade latency for area on the Actel fabric. The internal slice adder is built from the team's full-adder cells.

---
 rtl/multicycle_adder.sv | 130 +++++++++++++
 tb/tb_multicycle_adder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor: SLICE bits per clock through a registered carry chain.
// Define MULTICYCLE_ADDER_SATURATE_EN to clamp the result on signed overflow.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_sum;
  logic             chain;
  logic             sl_cmsb;
  logic             sl_cout;
  logic [WIDTH-1:0] work_next;
  logic             last;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

`ifdef MULTICYCLE_ADDER_SATURATE_EN
  // A wrapped result with MSB set came from positive overflow, and vice versa.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] r);
    return r[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  endfunction
`endif

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CNT_W'(i)) begin
        sl_a = op_a[i*SLICE +: SLICE];
        sl_b = op_b[i*SLICE +: SLICE];
      end
    end
    chain   = carry;
    sl_cmsb = carry;
    sl_sum  = '0;
    for (int j = 0; j < SLICE; j++) begin
      sl_cmsb = chain;
      {chain, sl_sum[j]} = full_add(sl_a[j], sl_b[j], chain);
    end
    sl_cout   = chain;
    work_next = work;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CNT_W'(i)) work_next[i*SLICE +: SLICE] = sl_sum;
    end
    last = (cnt == CNT_W'(NSLICE - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      work     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            work  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= sl_cout;
          cnt   <= cnt + CNT_W'(1);
          // Final slice: publish result; outputs held untouched until here.
          if (last) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            cout     <= sl_cout;
            overflow <= sl_cmsb ^ sl_cout;
`ifdef MULTICYCLE_ADDER_SATURATE_EN
            sum      <= (sl_cmsb ^ sl_cout) ? saturate(work_next) : work_next;
`else
            sum      <= work_next;
`endif
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder (WIDTH=16, SLICE=4).
module tb_multicycle_adder;
  localparam int W  = 16;
  localparam int S  = 4;
  localparam int NS = W / S;

  logic         clk = 1'b0;
  logic         rst, start, cin, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, overflow;
  logic [W-1:0] sum;

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  typedef struct packed {
    logic         ovf;
    logic         co;
    logic [W-1:0] s;
  } res_t;

  res_t exp_q[$];
  res_t last_exp;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic [W:0]   r;
    res_t         e;
    yy    = sb ? ~y : y;
    r     = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    e.co  = r[W];
    e.ovf = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
    e.s   = r[W-1:0];
`ifdef MULTICYCLE_ADDER_SATURATE_EN
    if (e.ovf) e.s = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("sum", {16'd0, sum}, {16'd0, e.s});
        chk("cout", {31'd0, cout}, {31'd0, e.co});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        last_exp = e;
      end
    end
  end

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb, input bit push);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = sb; start = 1'b1;
    if (push) exp_q.push_back(model(x, y, ci, sb));
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", {31'd0, busy}, 32'd1);
    chk("hold_sum", {16'd0, sum}, {16'd0, last_exp.s});
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic [W-1:0] ops_a [8] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h00FF, 16'h0010, 16'h8000, 16'hABCD};
    logic [W-1:0] ops_b [8] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0F00, 16'h0001, 16'h8000, 16'h1234};
    logic         ops_c [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         ops_s [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h0001; cin = 1'b0; sub = 1'b0;
    last_exp = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {31'd0, busy}, 32'd0);

    launch(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    wait_done(n);
    chk("latency_basic", n, NS);

    for (int i = 0; i < 8; i++) begin
      launch(ops_a[i], ops_b[i], ops_c[i], ops_s[i], 1'b1);
      wait_done(n);
      chk("latency_table", n, NS);
    end
    for (int i = 0; i < 6; i++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      wait_done(n);
    end

    // start re-pulsed during RUN with different operands must be ignored
    launch(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    repeat (NS + 3) @(negedge clk);
    chk("ignored_start_idle", {31'd0, busy}, 32'd0);

    // back-to-back: start held in the DONE cycle
    launch(16'h0100, 16'h0200, 1'b0, 1'b0, 1'b1);
    wait_done(n);
    a = 16'h7000; b = 16'h1000; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back(model(16'h7000, 16'h1000, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("b2b_spacing", n + 1, NS + 1);
    @(negedge clk);

    // reset asserted on the second RUN cycle discards the operation
    launch(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    last_exp = '0;
    repeat (NS + 2) @(negedge clk);
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    launch(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    wait_done(n);
    chk("latency_after_rst", n, NS);
    @(negedge clk);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
